ctrl_credit_dispatcher: RTL

Credit-based selector generator for the ctrl_demux fan-out stage in front of replicated engines (e.g. D_COUNT decrypt engines). It picks a target engine round-robin among engines with free credit and broadcasts the engine index as a selector token to REPLICATED_OUT_NUM demux selector ports, one per request field channel. Each lane has its own handshake. Per-engine completions return credits, which bounds the requests outstanding at each engine.

---
 rtl/ctrl_dispatch_pkg.sv | 21 ++
 rtl/ctrl_rr_pick.sv | 26 ++
 rtl/ctrl_credit_dispatcher.sv | 118 +++++++++++
 3 files changed

// File: rtl/ctrl_dispatch_pkg.sv
// Shared types and helpers for the credit-based selector dispatcher.
package ctrl_dispatch_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    if (ptr + 32'd1 >= n) begin
      return 32'd0;
    end else begin
      return ptr + 32'd1;
    end
  endfunction

  function automatic int unsigned credit_width(input int unsigned credits);
    return $clog2(credits + 32'd1);
  endfunction

endpackage

// File: rtl/ctrl_rr_pick.sv
// Rotate-priority picker: first set bit of eligible scanning upward from ptr, wrapping at N.
module ctrl_rr_pick #(
  parameter int N = 3,
  parameter int W = 2
) (
  input  logic [N-1:0] eligible,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] index
);

  // Scan from farthest to nearest so the nearest eligible candidate wins.
  always_comb begin
    found = 1'b0;
    index = {W{1'b0}};
    for (int k = N - 1; k >= 0; k--) begin
      if (eligible[W'((int'(ptr) + k) % N)]) begin
        found = 1'b1;
        index = W'((int'(ptr) + k) % N);
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/ctrl_credit_dispatcher.sv
// Picks an engine with free credit round-robin and broadcasts its index to every
// demux selector lane; per-engine completions return credits.
module ctrl_credit_dispatcher
  import ctrl_dispatch_pkg::*;
#(
  parameter int D_COUNT            = 3,
  parameter int DISPATCH_WIDTH     = 2,
  parameter int REPLICATED_OUT_NUM = 5,
  parameter int CREDITS            = 4,
  localparam int CREDIT_WIDTH      = int'(credit_width(CREDITS))
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         enable,
  output logic [REPLICATED_OUT_NUM*DISPATCH_WIDTH-1:0] m_selector_tdata,
  output logic [REPLICATED_OUT_NUM-1:0]                m_selector_tvalid,
  input  logic [REPLICATED_OUT_NUM-1:0]                m_selector_tready,
  input  logic [D_COUNT-1:0]                           s_done_tvalid,
  output logic [D_COUNT-1:0]                           s_done_tready,
  output logic [D_COUNT*CREDIT_WIDTH-1:0]              credits,
  output logic                                         err_credit_overflow
);

  localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(CREDITS);

  logic [REPLICATED_OUT_NUM-1:0] pend;
  logic [DISPATCH_WIDTH-1:0]     sel;
  logic [DISPATCH_WIDTH-1:0]     rr_ptr;
  logic [CREDIT_WIDTH-1:0]       credit     [D_COUNT];
  logic [CREDIT_WIDTH-1:0]       credit_nxt [D_COUNT];
  logic                          done_rdy;
  logic                          overflow_s;
  logic [D_COUNT-1:0]            eligible_s;
  logic                          found_s;
  logic [DISPATCH_WIDTH-1:0]     pick_s;
  logic                          last_hs_s;
  logic                          load_s;
  state_e                        state_s;

  assign state_s   = (pend != {REPLICATED_OUT_NUM{1'b0}}) ? ST_ISSUE : ST_IDLE;
  assign last_hs_s = (state_s == ST_ISSUE) && ((pend & ~m_selector_tready) == {REPLICATED_OUT_NUM{1'b0}});
  assign load_s    = enable && found_s && ((state_s == ST_IDLE) || last_hs_s);

  genvar j;
  generate
    for (j = 0; j < D_COUNT; j++) begin : g_elig
      assign eligible_s[j] = (credit[j] != {CREDIT_WIDTH{1'b0}});
      assign credits[j*CREDIT_WIDTH +: CREDIT_WIDTH] = credit[j];
    end
  endgenerate

  ctrl_rr_pick #(
    .N (D_COUNT),
    .W (DISPATCH_WIDTH)
  ) u_pick (
    .eligible (eligible_s),
    .ptr      (rr_ptr),
    .found    (found_s),
    .index    (pick_s)
  );

  assign m_selector_tvalid = pend;
  assign m_selector_tdata  = {REPLICATED_OUT_NUM{sel}};
  assign s_done_tready     = {D_COUNT{done_rdy}};

  // Per-engine credit: +done -issue; a done into a full counter is dropped and flagged.
  always_comb begin
    overflow_s = 1'b0;
    for (int k = 0; k < D_COUNT; k++) begin
      logic issue_k;
      logic done_k;
      issue_k       = load_s && (pick_s == DISPATCH_WIDTH'(k));
      done_k        = s_done_tvalid[k] && done_rdy;
      credit_nxt[k] = credit[k];
      if (done_k && !issue_k) begin
        if (credit[k] == CREDIT_MAX) begin
          overflow_s = 1'b1;
        end else begin
          credit_nxt[k] = credit[k] + CREDIT_WIDTH'(1);
        end
      end else if (issue_k && !done_k) begin
        credit_nxt[k] = credit[k] - CREDIT_WIDTH'(1);
      end else begin
        credit_nxt[k] = credit[k];
      end
    end
  end

  // Token, lane, pointer and credit state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend                <= {REPLICATED_OUT_NUM{1'b0}};
      sel                 <= {DISPATCH_WIDTH{1'b0}};
      rr_ptr              <= {DISPATCH_WIDTH{1'b0}};
      done_rdy            <= 1'b0;
      err_credit_overflow <= 1'b0;
      for (int k = 0; k < D_COUNT; k++) begin
        credit[k] <= CREDIT_MAX;
      end
    end else begin
      done_rdy            <= 1'b1;
      err_credit_overflow <= err_credit_overflow | overflow_s;
      for (int k = 0; k < D_COUNT; k++) begin
        credit[k] <= credit_nxt[k];
      end
      if (load_s) begin
        pend   <= {REPLICATED_OUT_NUM{1'b1}};
        sel    <= pick_s;
        rr_ptr <= DISPATCH_WIDTH'(rr_next(32'(pick_s), 32'(D_COUNT)));
      end else begin
        pend   <= pend & ~m_selector_tready;
        sel    <= sel;
        rr_ptr <= rr_ptr;
      end
    end
  end

endmodule
